// File: rtl/phys_freelist_pkg.sv
// Shared sizing, tag types and small bitmap helpers for the physical-register free list.
package phys_freelist_pkg;

  localparam int N          = 3;
  localparam int PHYS_REGS  = 64;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_TAG_W = $clog2(PHYS_REGS);
  localparam int CNT_W      = $clog2(PHYS_REGS + 1);

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  typedef logic [PHYS_REGS-1:0]  phys_vec_t;

  // Tags below ARCH_REGS hold the initial architectural mapping; the rest start free.
  function automatic phys_vec_t reset_free_vec();
    phys_vec_t v;
    for (int i = 0; i < PHYS_REGS; i++) begin
      v[i] = (i >= ARCH_REGS);
    end
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input phys_vec_t v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/freelist_psel.sv
// Cascaded lowest-set-bit selector: slot i gets the (i+1)-th lowest set bit of free_vec,
// or all zeros once the vector runs out of set bits.
module freelist_psel #(
  parameter int N = 3,
  parameter int W = 64
) (
  input  logic [W-1:0]        free_vec,
  output logic [N-1:0][W-1:0] grant
);

  logic [N-1:0][W-1:0] avail;

  assign avail[0] = free_vec;

  for (genvar i = 0; i < N; i++) begin : g_slot
    // Two's-complement trick isolates the lowest set bit; zero input yields zero.
    assign grant[i] = avail[i] & (~avail[i] + W'(1));
    if (i < N - 1) begin : g_next
      assign avail[i+1] = avail[i] & ~grant[i];
    end
  end

endmodule

// File: rtl/phys_freelist.sv
// R10K-style physical register free list: speculative bitmap feeds dispatch grants,
// architectural bitmap tracks committed state and is the restore point on mispredict.
module phys_freelist
  import phys_freelist_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N-1:0]                      alloc_req,
  output logic [N-1:0][PHYS_REGS-1:0]       granted_regs,
  output logic [CNT_W-1:0]                  free_slots,
  input  logic [N-1:0]                      retire_valid,
  input  logic [N-1:0]                      retire_has_rd,
  input  logic [N-1:0][PHYS_TAG_W-1:0]      retire_phys_rd,
  input  logic [N-1:0][PHYS_TAG_W-1:0]      retire_prev_phys,
  input  logic                              mispredict
);

  phys_vec_t spec_free;
  phys_vec_t arch_free;
  phys_vec_t spec_free_next;
  phys_vec_t arch_free_next;
  phys_vec_t alloc_clear;
  phys_vec_t retire_set;

  // Grants depend only on the registered speculative bitmap, so retire frees never bypass.
  freelist_psel #(
    .N (N),
    .W (PHYS_REGS)
  ) u_psel (
    .free_vec (spec_free),
    .grant    (granted_regs)
  );

  // Collect the one-hot grants that dispatch actually consumes this cycle.
  always_comb begin
    alloc_clear = '0;
    for (int i = 0; i < N; i++) begin
      if (alloc_req[i]) begin
        alloc_clear = alloc_clear | granted_regs[i];
      end
    end
  end

  // Apply retires oldest-first so a later slot's T_old can release an earlier slot's rd.
  always_comb begin
    arch_free_next = arch_free;
    retire_set     = '0;
    for (int i = 0; i < N; i++) begin
      if (retire_valid[i] && retire_has_rd[i]) begin
        if (retire_phys_rd[i] != '0) begin
          arch_free_next[retire_phys_rd[i]] = 1'b0;
        end
        if (retire_prev_phys[i] != '0) begin
          arch_free_next[retire_prev_phys[i]] = 1'b1;
          retire_set[retire_prev_phys[i]]     = 1'b1;
        end
      end
    end
  end

  // Mispredict restores from committed state (including this cycle's retires) and drops allocs.
  always_comb begin
    spec_free_next = (spec_free & ~alloc_clear) | retire_set;
    if (mispredict) begin
      spec_free_next = arch_free_next;
    end
  end

  // Bitmap registers; reset dominates mispredict.
  always_ff @(posedge clock) begin
    if (reset) begin
      spec_free <= reset_free_vec();
      arch_free <= reset_free_vec();
    end else begin
      spec_free <= spec_free_next;
      arch_free <= arch_free_next;
    end
  end

  assign free_slots = popcount(spec_free);

  // Usage checks: committed free count is conserved, no alloc without an offer, no double free.
  always @(posedge clock) begin
    if (!reset) begin
      assert (popcount(arch_free) == CNT_W'(PHYS_REGS - ARCH_REGS));
      for (int i = 0; i < N; i++) begin
        if (alloc_req[i] && !mispredict) begin
          assert (granted_regs[i] != '0);
        end
        if (retire_valid[i] && retire_has_rd[i] && (retire_prev_phys[i] != '0)) begin
          assert (!spec_free[retire_prev_phys[i]]);
        end
      end
    end
  end

endmodule
